// File: rtl/logic_accum_unit.sv
// Registered bitwise AND/OR/XOR/NOR unit with single-beat and multi-beat accumulate modes.
// Valid/ready on both sides; a held result can be replaced by a new one on the same edge.
module logic_accum_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_InValid,
  output logic             o_InReady,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_Op,
  input  logic             i_Accum,
  input  logic             i_Last,
  output logic             o_OutValid,
  input  logic             i_OutReady,
  output logic [WIDTH-1:0] o_Out,
  output logic             o_OutZero,
  output logic [CNT_W-1:0] o_BeatCount
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           r_state, w_stateNext;
  logic [1:0]       r_op, w_opNext;
  logic [WIDTH-1:0] r_acc, w_accNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic [WIDTH-1:0] r_out, w_outNext;
  logic             r_outValid, w_outValidNext;
  logic             r_outZero, w_outZeroNext;
  logic [CNT_W-1:0] r_beatCount, w_beatCountNext;

  logic             w_accept;
  logic [WIDTH-1:0] w_res;
  logic [CNT_W-1:0] w_cntInc;

  function automatic logic [WIDTH-1:0] applyOp(input logic [1:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (op)
      2'b00:   applyOp = x & y;
      2'b01:   applyOp = x | y;
      2'b10:   applyOp = x ^ y;
      default: applyOp = ~(x | y);
    endcase
  endfunction

  assign o_InReady   = !r_outValid || i_OutReady;
  assign w_accept    = i_InValid && o_InReady;
  // Beat counter sticks at all-ones instead of wrapping
  assign w_cntInc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  assign o_OutValid  = r_outValid;
  assign o_Out       = r_out;
  assign o_OutZero   = r_outZero;
  assign o_BeatCount = r_beatCount;

  always_comb begin
    w_stateNext     = r_state;
    w_opNext        = r_op;
    w_accNext       = r_acc;
    w_cntNext       = r_cnt;
    w_outNext       = r_out;
    w_outZeroNext   = r_outZero;
    w_beatCountNext = r_beatCount;
    w_outValidNext  = r_outValid && !i_OutReady;
    w_res           = '0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          w_res = applyOp(i_Op, i_A, i_B);
          if (i_Accum && !i_Last) begin
            w_accNext   = w_res;
            w_cntNext   = CNT_W'(1);
            w_opNext    = i_Op;
            w_stateNext = ACCUM;
          end else begin
            w_outNext       = w_res;
            w_outZeroNext   = (w_res == '0);
            w_beatCountNext = CNT_W'(1);
            w_outValidNext  = 1'b1;
          end
        end
        default: begin
          // Fold uses the op latched on the packet's first beat; B is ignored here
          w_res = applyOp(r_op, r_acc, i_A);
          if (i_Last) begin
            w_outNext       = w_res;
            w_outZeroNext   = (w_res == '0);
            w_beatCountNext = w_cntInc;
            w_outValidNext  = 1'b1;
            w_stateNext     = IDLE;
          end else begin
            w_accNext = w_res;
            w_cntNext = w_cntInc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_op        <= 2'b00;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_outValid  <= 1'b0;
      r_outZero   <= 1'b0;
      r_beatCount <= '0;
    end else begin
      r_op        <= w_opNext;
      r_acc       <= w_accNext;
      r_cnt       <= w_cntNext;
      r_out       <= w_outNext;
      r_outValid  <= w_outValidNext;
      r_outZero   <= w_outZeroNext;
      r_beatCount <= w_beatCountNext;
    end
  end

endmodule
